ucsbece154b_mem_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the instruction-fetch side (F stage) and the data side (M stage loads/stores) of the pipelined RISC-V core.
- Grants one requester at a time, holds the grant until the memory acknowledges, and returns the read data with a one-cycle ready pulse.
- Exports stall signals that the hazard unit ORs into StallF and into StallD/StallE/StallM.
- Data side has fixed priority; a starvation counter guarantees fetch progress.

---
 rtl/ucsbece154b_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and data access (D).
// D has fixed priority; a starvation counter lets fetch win after STARVE_LIMIT denied arbitrations.
module ucsbece154b_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq_i,
    input  logic [31:0] IAddr_i,
    output logic        IReady_o,
    output logic [31:0] IRdata_o,
    output logic        IStall_o,
    input  logic        DReq_i,
    input  logic        DWe_i,
    input  logic [31:0] DAddr_i,
    input  logic [31:0] DWdata_i,
    output logic        DReady_o,
    output logic [31:0] DRdata_o,
    output logic        DStall_o,
    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWdata_o,
    input  logic        MemAck_i,
    input  logic [31:0] MemRdata_i,
    output logic [1:0]  dbg_state_o,
    output logic [3:0]  dbg_starve_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;
    logic        ready_i_q;
    logic        ready_d_q;
    logic [31:0] rdata_i_q;
    logic [31:0] rdata_d_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        i_eff;
    logic        d_eff;
    logic        grant_i;
    logic        grant_d;

    // Handshake: a requester holds xReq with stable operands until its one-cycle xReady pulse;
    // the request is masked while that pulse is high so it cannot be granted a second time.
    always_comb begin
        i_eff        = IReq_i & ~ready_i_q;
        d_eff        = DReq_i & ~ready_d_q;
        grant_i      = (state_q == IDLE) & i_eff & ((starve_cnt_q == LIMIT) | ~d_eff);
        grant_d      = (state_q == IDLE) & d_eff & ~grant_i;
        starve_cnt_d = 4'd0;
        if (i_eff) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            ready_i_q    <= 1'b0;
            ready_d_q    <= 1'b0;
            rdata_i_q    <= 32'd0;
            rdata_d_q    <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            ready_i_q <= 1'b0;
            ready_d_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q      <= SERVE_I;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= IAddr_i;
                        starve_cnt_q <= 4'd0;
                    end else if (grant_d) begin
                        state_q      <= SERVE_D;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= DWe_i;
                        mem_addr_q   <= DAddr_i;
                        mem_wdata_q  <= DWdata_i;
                        starve_cnt_q <= starve_cnt_d;
                    end
                end
                SERVE_I: begin
                    if (MemAck_i) begin
                        ready_i_q <= 1'b1;
                        rdata_i_q <= MemRdata_i;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (MemAck_i) begin
                        ready_d_q <= 1'b1;
                        // Stores leave the last load result visible.
                        if (!mem_we_q) begin
                            rdata_d_q <= MemRdata_i;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign IReady_o         = ready_i_q;
    assign IRdata_o         = rdata_i_q;
    assign IStall_o         = IReq_i & ~ready_i_q;
    assign DReady_o         = ready_d_q;
    assign DRdata_o         = rdata_d_q;
    assign DStall_o         = DReq_i & ~ready_d_q;
    assign MemReq_o         = mem_req_q;
    assign MemWe_o          = mem_we_q;
    assign MemAddr_o        = mem_addr_q;
    assign MemWdata_o       = mem_wdata_q;
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = starve_cnt_q;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for ucsbece154b_mem_arbiter: memory model with programmable ack latency,
// grant monitor feeding a scoreboard, and one task per scenario.
module tb_ucsbece154b_mem_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_I    = 2'd1;
    localparam logic [1:0] S_D    = 2'd2;

    logic        clk;
    logic        reset;
    logic        IReq_i;
    logic [31:0] IAddr_i;
    logic        IReady_o;
    logic [31:0] IRdata_o;
    logic        IStall_o;
    logic        DReq_i;
    logic        DWe_i;
    logic [31:0] DAddr_i;
    logic [31:0] DWdata_i;
    logic        DReady_o;
    logic [31:0] DRdata_o;
    logic        DStall_o;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWdata_o;
    logic        MemAck_i;
    logic [31:0] MemRdata_i;
    logic [1:0]  dbg_state_o;
    logic [3:0]  dbg_starve_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory model controls and observations
    int          mem_lat    = 1;
    int          mem_cnt    = 0;
    logic        stray_ack  = 1'b0;
    logic [31:0] wr_addr    = 32'd0;
    logic [31:0] wr_data    = 32'd0;

    // grant monitor and scoreboard
    logic        mon_en       = 1'b0;
    logic        memreq_prev  = 1'b0;
    int          d_grants     = 0;
    int          d_pulses     = 0;
    logic [1:0]  grant_q[$];
    logic [3:0]  cnt_q[$];
    logic [1:0]  exp_q[$];
    logic [3:0]  exp_cnt_q[$];

    ucsbece154b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IReady_o(IReady_o), .IRdata_o(IRdata_o), .IStall_o(IStall_o),
        .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWdata_i(DWdata_i),
        .DReady_o(DReady_o), .DRdata_o(DRdata_o), .DStall_o(DStall_o),
        .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o), .MemWdata_o(MemWdata_o),
        .MemAck_i(MemAck_i), .MemRdata_i(MemRdata_i),
        .dbg_state_o(dbg_state_o), .dbg_starve_cnt_o(dbg_starve_cnt_o)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: ack arrives mem_lat cycles after the first MemReq_o cycle.
    always @(negedge clk) begin
        if (MemReq_o === 1'b1) mem_cnt = mem_cnt + 1;
        else                   mem_cnt = 0;
        MemAck_i   = stray_ack || (MemReq_o === 1'b1 && mem_cnt == mem_lat + 1);
        MemRdata_i = stray_ack ? 32'hBAD0_BAD0 : mem_word(MemAddr_o);
        if (MemAck_i && !stray_ack && MemWe_o === 1'b1) begin
            wr_addr = MemAddr_o;
            wr_data = MemWdata_o;
        end
    end

    always @(negedge clk) begin
        if (MemReq_o === 1'b1 && !memreq_prev) begin
            if (dbg_state_o == S_D) d_grants = d_grants + 1;
            if (mon_en) begin
                grant_q.push_back(dbg_state_o);
                cnt_q.push_back(dbg_starve_cnt_o);
            end
        end
        if (DReady_o === 1'b1) d_pulses = d_pulses + 1;
        memreq_prev = (MemReq_o === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; IReq_i = 1'b0; IAddr_i = 32'd0; DReq_i = 1'b0; DWe_i = 1'b0;
        DAddr_i = 32'd0; DWdata_i = 32'd0;
        tick(); tick();
        n_cmp++;
        if ({MemReq_o, MemWe_o, IReady_o, DReady_o, dbg_state_o, dbg_starve_cnt_o} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want %b", {MemReq_o, MemWe_o, IReady_o, DReady_o, dbg_state_o, dbg_starve_cnt_o}, 10'd0);
        end
        n_cmp++;
        if ({MemAddr_o, MemWdata_o, IRdata_o, DRdata_o} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {MemAddr_o, MemWdata_o, IRdata_o, DRdata_o});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        mem_lat = 1;
        @(negedge clk);
        IReq_i = 1'b1; IAddr_i = 32'h0000_0010;
        #1;
        n_cmp++;
        if (IStall_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b want 1", IStall_o); end
        tick();
        n_cmp++;
        if ({MemReq_o, MemWe_o, IStall_o, dbg_state_o} !== {3'b101, S_I} || MemAddr_o !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_grant_c1: got req/we/stall/st=%b addr=%h want 10101 addr=10",
                     {MemReq_o, MemWe_o, IStall_o, dbg_state_o}, MemAddr_o);
        end
        tick();
        n_cmp++;
        if ({IReady_o, IStall_o} !== 2'b01) begin n_fail++; $display("FAIL fetch_wait_c2: got %b want 01", {IReady_o, IStall_o}); end
        tick();
        n_cmp++;
        if ({IReady_o, IStall_o, MemReq_o} !== 3'b100 || IRdata_o !== 32'h0010_FFEF) begin
            n_fail++;
            $display("FAIL fetch_ready_c3: got rdy/stall/req=%b data=%h want 100 data=0010ffef",
                     {IReady_o, IStall_o, MemReq_o}, IRdata_o);
        end
        @(negedge clk);
        IReq_i = 1'b0;
        tick();
        n_cmp++;
        if ({IReady_o, MemReq_o, dbg_state_o} !== {2'b00, S_IDLE}) begin
            n_fail++;
            $display("FAIL fetch_pulse_c4: got %b want 0000", {IReady_o, MemReq_o, dbg_state_o});
        end
    endtask

    task automatic test_simultaneous();
        int dg0;
        int dp0;
        dg0 = d_grants; dp0 = d_pulses;
        mem_lat = 1;
        @(negedge clk);
        IReq_i = 1'b1; IAddr_i = 32'h40; DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h100;
        tick();
        n_cmp++;
        if (dbg_state_o !== S_D || MemAddr_o !== 32'h100 || MemWe_o !== 1'b0 ||
            dbg_starve_cnt_o !== 4'd1 || {IStall_o, DStall_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_dgrant: got st=%0d addr=%h we=%b cnt=%0d stalls=%b want st=2 addr=100 we=0 cnt=1 stalls=11",
                     dbg_state_o, MemAddr_o, MemWe_o, dbg_starve_cnt_o, {IStall_o, DStall_o});
        end
        tick(); tick();
        n_cmp++;
        if ({DReady_o, IReady_o, IStall_o, DStall_o} !== 4'b1010 || DRdata_o !== 32'h0100_FEFF) begin
            n_fail++;
            $display("FAIL simul_dready: got rdy/stalls=%b data=%h want 1010 data=0100feff",
                     {DReady_o, IReady_o, IStall_o, DStall_o}, DRdata_o);
        end
        @(negedge clk);
        DReq_i = 1'b0;
        tick();
        n_cmp++;
        if (dbg_state_o !== S_I || MemAddr_o !== 32'h40 || dbg_starve_cnt_o !== 4'd0 || DReady_o !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_igrant: got st=%0d addr=%h cnt=%0d drdy=%b want st=1 addr=40 cnt=0 drdy=0",
                     dbg_state_o, MemAddr_o, dbg_starve_cnt_o, DReady_o);
        end
        tick(); tick();
        n_cmp++;
        if (IReady_o !== 1'b1 || IRdata_o !== 32'h0040_FFBF) begin
            n_fail++;
            $display("FAIL simul_iready: got rdy=%b data=%h want 1 0040ffbf", IReady_o, IRdata_o);
        end
        @(negedge clk);
        IReq_i = 1'b0;
        tick();
        n_cmp++;
        if (d_grants - dg0 !== 1 || d_pulses - dp0 !== 1) begin
            n_fail++;
            $display("FAIL simul_no_dup: got grants=%0d pulses=%0d want 1 1", d_grants - dg0, d_pulses - dp0);
        end
    endtask

    task automatic test_store();
        mem_lat = 3;
        @(negedge clk);
        DReq_i = 1'b1; DWe_i = 1'b1; DAddr_i = 32'h200; DWdata_i = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if ({MemReq_o, MemWe_o, DReady_o} !== 3'b110 || MemWdata_o !== 32'hDEAD_BEEF || MemAddr_o !== 32'h200) begin
                n_fail++;
                $display("FAIL store_hold_c%0d: got req/we/rdy=%b wdata=%h addr=%h want 110 deadbeef 200",
                         c, {MemReq_o, MemWe_o, DReady_o}, MemWdata_o, MemAddr_o);
            end
        end
        tick();
        n_cmp++;
        if ({DReady_o, MemReq_o} !== 2'b10 || DRdata_o !== 32'h0100_FEFF) begin
            n_fail++;
            $display("FAIL store_ready: got rdy/req=%b drdata=%h want 10 0100feff", {DReady_o, MemReq_o}, DRdata_o);
        end
        n_cmp++;
        if (wr_addr !== 32'h200 || wr_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_mem: got addr=%h data=%h want 200 deadbeef", wr_addr, wr_data);
        end
        @(negedge clk);
        DReq_i = 1'b0; DWe_i = 1'b0;
        tick();
        n_cmp++;
        if (DReady_o !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %b want 0", DReady_o); end
    endtask

    // Fetch drops its request in each D ready cycle so every D grant sees a competing fetch.
    task automatic test_starvation();
        logic done;
        done = 1'b0;
        mem_lat = 1;
        grant_q.delete(); cnt_q.delete(); exp_q.delete(); exp_cnt_q.delete();
        exp_q = '{S_D, S_D, S_D, S_D, S_I};
        exp_cnt_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        mon_en = 1'b1;
        @(negedge clk);
        IAddr_i = 32'h80; DWe_i = 1'b0; DAddr_i = 32'h400; DReq_i = 1'b1; IReq_i = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (IReady_o === 1'b1) begin
                IReq_i = 1'b0; DReq_i = 1'b0; done = 1'b1;
            end else begin
                if (DReady_o === 1'b1) DAddr_i = DAddr_i + 32'd4;
                IReq_i = (DReady_o !== 1'b1);
            end
        end
        mon_en = 1'b0;
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL starve_timeout: fetch never served within 100 cycles"); end
        n_cmp++;
        if (grant_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL starve_len: got %0d grants want %0d", grant_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++) begin
            n_cmp++;
            if (grant_q[i] !== exp_q[i] || cnt_q[i] !== exp_cnt_q[i]) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got st=%0d cnt=%0d want st=%0d cnt=%0d",
                         i, grant_q[i], cnt_q[i], exp_q[i], exp_cnt_q[i]);
            end
        end
        tick();
        n_cmp++;
        if (IRdata_o !== 32'h0080_FF7F || DRdata_o !== 32'h040C_FBF3 || dbg_starve_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL starve_data: got i=%h d=%h cnt=%0d want 0080ff7f 040cfbf3 0",
                     IRdata_o, DRdata_o, dbg_starve_cnt_o);
        end
    endtask

    task automatic test_stray_ack();
        stray_ack = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({IReady_o, DReady_o, MemReq_o, dbg_state_o} !== {3'b000, S_IDLE} ||
            IRdata_o !== 32'h0080_FF7F || DRdata_o !== 32'h040C_FBF3) begin
            n_fail++;
            $display("FAIL stray_ack: got rdy/req/st=%b i=%h d=%h want 00000 0080ff7f 040cfbf3",
                     {IReady_o, DReady_o, MemReq_o, dbg_state_o}, IRdata_o, DRdata_o);
        end
        stray_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mem_lat = 5;
        @(negedge clk);
        DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h300;
        tick();
        n_cmp++;
        if (dbg_state_o !== S_D || MemReq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_grant: got st=%0d req=%b want 2 1", dbg_state_o, MemReq_o);
        end
        tick();
        @(negedge clk);
        reset = 1'b1; DReq_i = 1'b0;
        tick();
        n_cmp++;
        if ({MemReq_o, DReady_o, dbg_state_o} !== {2'b00, S_IDLE} || DRdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got req/rdy/st=%b drdata=%h want 0000 0", {MemReq_o, DReady_o, dbg_state_o}, DRdata_o);
        end
        stray_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({IReady_o, DReady_o, MemReq_o, dbg_state_o} !== {3'b000, S_IDLE} || DRdata_o !== 32'd0 || IRdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_late_ack: got rdy/req/st=%b d=%h i=%h want 00000 0 0",
                     {IReady_o, DReady_o, MemReq_o, dbg_state_o}, DRdata_o, IRdata_o);
        end
        stray_ack = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_starvation();
        test_stray_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
